// File: rtl/contador_linha_pkg.sv
// contador_pkg: shared widths, display limit and parameter sanity check for the line counter
// Ports: none (package only)
package contador_pkg;
    localparam int CNT_W       = 3;
    localparam int MAX_DISPLAY = 6;
    function automatic bit params_ok(input int max_count, input int debounce_cycles);
        return (max_count <= MAX_DISPLAY) && (debounce_cycles >= 2);
    endfunction
endpackage

// File: rtl/contador_linha_if.sv
// contador_linha_if: raw buttons/switch in, decoder drive and status flags out
// master: btn_entra, btn_sai, liga out; v, x, y, z, cheio, vazio, erro in
// slave:  the mirror image, used by contador_linha
interface contador_linha_if;
    logic btn_entra;
    logic btn_sai;
    logic liga;
    logic v;
    logic x;
    logic y;
    logic z;
    logic cheio;
    logic vazio;
    logic erro;
    modport master (output btn_entra, btn_sai, liga, input v, x, y, z, cheio, vazio, erro);
    modport slave  (input btn_entra, btn_sai, liga, output v, x, y, z, cheio, vazio, erro);
endinterface

// File: rtl/contador_linha_debounce_botao.sv
// debounce_botao: 2-flop sync, debounce counter and press-edge pulse for one active-low button
// clk, rst_n : clock, async active-low reset
// btn_n      : raw button, active-low, asynchronous
// nivel      : debounced level (1 = released)
// pulso      : one-cycle pulse on the debounced release->press transition
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic nivel,
    output logic pulso
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1_q, s2_q, nivel_q, nivel_d, prev_q, mism, done;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        mism    = s2_q ^ nivel_q;
        done    = mism && (cnt_q == LAST);
        cnt_d   = (mism && !done) ? cnt_q + CW'(1) : '0;
        nivel_d = done ? s2_q : nivel_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            nivel_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_n;
            s2_q    <= s1_q;
            nivel_q <= nivel_d;
            prev_q  <= nivel_q;
            cnt_q   <= cnt_d;
        end
    end
    assign nivel = nivel_q;
    // prev_q lags nivel_q by one cycle, so the falling edge is visible for exactly one cycle
    assign pulso = prev_q & ~nivel_q;
endmodule

// File: rtl/contador_linha.sv
// contador_linha: debounced entry/exit buttons drive a saturating 0..MAX_COUNT occupancy counter
// clk, rst_n : clock, async active-low reset
// bus (slave): btn_entra, btn_sai, liga in; v (enable), x/y/z (count bits), cheio, vazio, erro out
module contador_linha
    import contador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_COUNT       = 6
) (
    input  logic clk,
    input  logic rst_n,
    contador_linha_if.slave bus
);
    if (!params_ok(MAX_COUNT, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("contador_linha: MAX_COUNT must be <= %0d and DEBOUNCE_CYCLES >= 2", MAX_DISPLAY);
    end
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_COUNT);
    logic liga1_q, liga2_q, erro_q, erro_d;
    logic pulso_e, pulso_s, nivel_e, nivel_s, inc, dec, full, empty;
    logic unused_niveis;
    logic [CNT_W-1:0] count_q, count_d;
    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entra (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_entra), .nivel(nivel_e), .pulso(pulso_e)
    );
    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sai (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_sai), .nivel(nivel_s), .pulso(pulso_s)
    );
    assign unused_niveis = nivel_e ^ nivel_s;
    // requests are gated by liga but the debouncers keep running, so a held button is never replayed
    always_comb begin
        inc     = liga2_q & pulso_e & ~pulso_s;
        dec     = liga2_q & pulso_s & ~pulso_e;
        full    = count_q == MAX_T;
        empty   = count_q == '0;
        erro_d  = (inc & full) | (dec & empty);
        count_d = (inc && !full) ? count_q + CNT_W'(1) : (dec && !empty) ? count_q - CNT_W'(1) : count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            liga1_q <= 1'b0;
            liga2_q <= 1'b0;
            count_q <= '0;
            erro_q  <= 1'b0;
        end else begin
            liga1_q <= bus.liga;
            liga2_q <= liga1_q;
            count_q <= count_d;
            erro_q  <= erro_d;
        end
    end
    assign bus.v     = liga2_q;
    assign bus.x     = count_q[2];
    assign bus.y     = count_q[1];
    assign bus.z     = count_q[0];
    assign bus.cheio = full;
    assign bus.vazio = empty;
    assign bus.erro  = erro_q;
endmodule

// File: tb/tb_contador_linha.sv
// tb_contador_linha: directed scenarios for contador_linha with DEBOUNCE_CYCLES=4, MAX_COUNT=6
module tb_contador_linha;
    logic clk = 1'b0;
    logic rst_n;
    int errors = 0;
    int checks = 0;
    logic [2:0] xyz, xyz7;
    logic e7, e8;
    always #5 clk = ~clk;
    contador_linha_if bus();
    contador_linha #(.DEBOUNCE_CYCLES(4), .MAX_COUNT(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign xyz = {bus.x, bus.y, bus.z};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // raw press held 20 cycles; samples xyz/erro on the 7th edge (update) and erro on the 8th
    task automatic press(input logic e, input logic s, output logic [2:0] x7, output logic er7, output logic er8);
        bus.btn_entra = ~e;
        bus.btn_sai   = ~s;
        tick(7);
        x7  = xyz;
        er7 = bus.erro;
        tick(1);
        er8 = bus.erro;
        tick(12);
        bus.btn_entra = 1'b1;
        bus.btn_sai   = 1'b1;
        tick(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        bus.liga = 1'b1; bus.btn_entra = 1'b1; bus.btn_sai = 1'b1; rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.v !== 1'b0) begin errors++; $display("FAIL reset_v: got %b expected 0", bus.v); end
        checks++; if (xyz !== 3'b000) begin errors++; $display("FAIL reset_xyz: got %b expected 000", xyz); end
        checks++; if (bus.vazio !== 1'b1 || bus.cheio !== 1'b0 || bus.erro !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got vazio=%b cheio=%b erro=%b expected 1 0 0", bus.vazio, bus.cheio, bus.erro);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        checks++; if (bus.v !== 1'b1) begin errors++; $display("FAIL reset_v_after: got %b expected 1", bus.v); end
    endtask

    task automatic test_debounce();
        bus.btn_entra = 1'b0;
        tick(3);
        bus.btn_entra = 1'b1;
        tick(10);
        checks++; if (xyz !== 3'b000) begin errors++; $display("FAIL glitch: got %b expected 000", xyz); end
        bus.btn_entra = 1'b0;
        tick(6);
        checks++; if (xyz !== 3'b000) begin errors++; $display("FAIL latency_early: got %b expected 000", xyz); end
        tick(1);
        checks++; if (xyz !== 3'b001) begin errors++; $display("FAIL latency_7: got %b expected 001", xyz); end
        tick(13);
        bus.btn_entra = 1'b1;
        tick(10);
        checks++; if (xyz !== 3'b001) begin errors++; $display("FAIL hold_once: got %b expected 001", xyz); end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_x;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_x = (i < 6) ? 3'(i + 1) : 3'd6;
            press(1'b1, 1'b0, xyz7, e7, e8);
            checks++; if (xyz7 !== exp_x) begin errors++; $display("FAIL sat_xyz[%0d]: got %b expected %b", i, xyz7, exp_x); end
            checks++; if (e7 !== (i == 6)) begin errors++; $display("FAIL sat_erro[%0d]: got %b expected %b", i, e7, i == 6); end
            checks++; if (e8 !== 1'b0) begin errors++; $display("FAIL sat_erro_len[%0d]: got %b expected 0", i, e8); end
        end
        checks++; if (bus.cheio !== 1'b1 || bus.vazio !== 1'b0) begin
            errors++; $display("FAIL sat_flags: got cheio=%b vazio=%b expected 1 0", bus.cheio, bus.vazio);
        end
    endtask

    task automatic test_empty();
        do_reset();
        press(1'b0, 1'b1, xyz7, e7, e8);
        checks++; if (xyz7 !== 3'b000) begin errors++; $display("FAIL empty_xyz: got %b expected 000", xyz7); end
        checks++; if (e7 !== 1'b1 || e8 !== 1'b0) begin errors++; $display("FAIL empty_erro: got %b%b expected 10", e7, e8); end
        checks++; if (bus.vazio !== 1'b1) begin errors++; $display("FAIL empty_vazio: got %b expected 1", bus.vazio); end
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, xyz7, e7, e8);
        checks++; if (xyz !== 3'b011) begin errors++; $display("FAIL up_to_3: got %b expected 011", xyz); end
        press(1'b0, 1'b1, xyz7, e7, e8);
        checks++; if (xyz7 !== 3'b010 || e7 !== 1'b0) begin errors++; $display("FAIL dec_3: got %b erro=%b expected 010 erro=0", xyz7, e7); end
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0, xyz7, e7, e8);
        checks++; if (xyz7 !== 3'b011) begin errors++; $display("FAIL back_to_3: got %b expected 011", xyz7); end
        press(1'b1, 1'b1, xyz7, e7, e8);
        checks++; if (xyz7 !== 3'b011 || e7 !== 1'b0 || e8 !== 1'b0) begin
            errors++; $display("FAIL simul: got %b erro=%b%b expected 011 erro=00", xyz7, e7, e8);
        end
    endtask

    task automatic test_off();
        bus.liga = 1'b0;
        tick(2);
        checks++; if (bus.v !== 1'b0) begin errors++; $display("FAIL off_v: got %b expected 0", bus.v); end
        press(1'b1, 1'b0, xyz7, e7, e8);
        checks++; if (xyz7 !== 3'b011 || e7 !== 1'b0) begin errors++; $display("FAIL off_drop: got %b erro=%b expected 011 erro=0", xyz7, e7); end
        bus.btn_entra = 1'b0;
        tick(10);
        bus.liga = 1'b1;
        tick(12);
        bus.btn_entra = 1'b1;
        tick(10);
        checks++; if (xyz !== 3'b011 || bus.v !== 1'b1) begin errors++; $display("FAIL held_on_liga: got %b v=%b expected 011 v=1", xyz, bus.v); end
    endtask

    task automatic test_reset_mid();
        bus.btn_entra = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        checks++; if (xyz !== 3'b000) begin errors++; $display("FAIL midrst_xyz: got %b expected 000", xyz); end
        bus.btn_entra = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(12);
        checks++; if (xyz !== 3'b000 || bus.erro !== 1'b0) begin errors++; $display("FAIL midrst_late: got %b erro=%b expected 000 erro=0", xyz, bus.erro); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_saturation();
        test_empty();
        test_simultaneous();
        test_off();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
